// File: rtl/sobel_stream_if.sv
// Byte-stream bundle for the Sobel unit: RX bytes in, TX bytes out with valid/ready, plus mode/status.
// The master side is the UART glue; the slave side is the Sobel unit.
interface sobel_stream_if;
  logic [1:0] mode;
  logic [7:0] rx_dados;
  logic       rx_pronto;
  logic       tx_pronto;
  logic [7:0] tx_dados;
  logic       tx_valido;
  logic       ocupado;
  logic       fim_imagem;

  modport master (
    output mode, rx_dados, rx_pronto, tx_pronto,
    input  tx_dados, tx_valido, ocupado, fim_imagem
  );

  modport slave (
    input  mode, rx_dados, rx_pronto, tx_pronto,
    output tx_dados, tx_valido, ocupado, fim_imagem
  );
endinterface

// File: rtl/sobel_stream_unit.sv
// Frame-buffered Sobel engine: receives a packed frame, computes one result pixel per cycle,
// then streams the packed result frame out under valid/ready.
//
// state     | meaning
// RECEBE    | writing RX bytes into the raw frame buffer
// CALCULA   | one result pixel per cycle in raster order
// TRANSMITE | streaming packed result bytes to the TX sink
module sobel_stream_unit #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 4,
  parameter int PIXEL_BITS = 4
) (
  input logic           clock,
  input logic           reset,
  sobel_stream_if.slave bus
);
  localparam int PPB    = 8 / PIXEL_BITS;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int NBYTES = NPIX / PPB;
  localparam int AW     = $clog2(NPIX);
  localparam int BW     = $clog2(NBYTES);
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  localparam int SW     = PIXEL_BITS + 4;
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(NBYTES - 1);
  localparam logic [SW-1:0] PIX_MAX = SW'((1 << PIXEL_BITS) - 1);

  typedef enum logic [1:0] {RECEBE, CALCULA, TRANSMITE} state_t;

  state_t          state_q;
  logic [BW-1:0]   rx_byte_q;
  logic [BW-1:0]   tx_byte_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [1:0]      mode_q;
  logic [7:0]      tx_dados_q;
  logic            tx_valido_q;
  logic            ocupado_q;
  logic            fim_q;

  logic [PIXEL_BITS-1:0] raw_q [NPIX];
  logic [PIXEL_BITS-1:0] res_q [NPIX];

  logic [XW-1:0]         xm, xp;
  logic [YW-1:0]         ym, yp;
  logic                  border;
  logic signed [SW-1:0]  gx, gy;
  logic [SW-1:0]         ax, ay, mag;
  logic [PIXEL_BITS-1:0] cur_pix, sat_pix, calc_pix_d;
  logic [BW-1:0]         tx_sel;
  logic [7:0]            tx_next_d;

  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  function automatic logic [AW-1:0] byte_addr(input logic [BW-1:0] b, input int k);
    return AW'(b) * AW'(PPB) + AW'(k);
  endfunction

  function automatic logic signed [SW-1:0] sx(input logic [PIXEL_BITS-1:0] p);
    return $signed({{(SW - PIXEL_BITS){1'b0}}, p});
  endfunction

  // Neighbour coordinates are clamped so border pixels never address outside the frame.
  always_comb begin
    xm      = (x_q == '0)     ? x_q : x_q - XW'(1);
    xp      = (x_q == X_LAST) ? x_q : x_q + XW'(1);
    ym      = (y_q == '0)     ? y_q : y_q - YW'(1);
    yp      = (y_q == Y_LAST) ? y_q : y_q + YW'(1);
    border  = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);
    gx = (sx(raw_q[pix_addr(xp, ym)]) + sx(raw_q[pix_addr(xp, y_q)]) + sx(raw_q[pix_addr(xp, y_q)])
          + sx(raw_q[pix_addr(xp, yp)]))
       - (sx(raw_q[pix_addr(xm, ym)]) + sx(raw_q[pix_addr(xm, y_q)]) + sx(raw_q[pix_addr(xm, y_q)])
          + sx(raw_q[pix_addr(xm, yp)]));
    gy = (sx(raw_q[pix_addr(xm, yp)]) + sx(raw_q[pix_addr(x_q, yp)]) + sx(raw_q[pix_addr(x_q, yp)])
          + sx(raw_q[pix_addr(xp, yp)]))
       - (sx(raw_q[pix_addr(xm, ym)]) + sx(raw_q[pix_addr(x_q, ym)]) + sx(raw_q[pix_addr(x_q, ym)])
          + sx(raw_q[pix_addr(xp, ym)]));
    ax      = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay      = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag     = ax + ay;
    sat_pix = (mag > PIX_MAX) ? PIX_MAX[PIXEL_BITS-1:0] : mag[PIXEL_BITS-1:0];
    cur_pix = raw_q[pix_addr(x_q, y_q)];
    case (mode_q)
      2'd1:    calc_pix_d = ~cur_pix;
      2'd2:    calc_pix_d = cur_pix;
      default: calc_pix_d = border ? '0 : sat_pix;
    endcase
  end

  // Byte to present next: byte 0 when leaving CALCULA, otherwise the one after the current.
  always_comb begin
    tx_next_d = '0;
    tx_sel    = (state_q == TRANSMITE) ? tx_byte_q + BW'(1) : '0;
    for (int k = 0; k < PPB; k++) begin
      tx_next_d[8-1-k*PIXEL_BITS -: PIXEL_BITS] = res_q[byte_addr(tx_sel, k)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (state_q == RECEBE && bus.rx_pronto) begin
        for (int k = 0; k < PPB; k++) begin
          raw_q[byte_addr(rx_byte_q, k)] <= bus.rx_dados[8-1-k*PIXEL_BITS -: PIXEL_BITS];
        end
      end
      if (state_q == CALCULA) begin
        res_q[pix_addr(x_q, y_q)] <= calc_pix_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RECEBE;
      rx_byte_q   <= '0;
      tx_byte_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= '0;
      tx_dados_q  <= '0;
      tx_valido_q <= 1'b0;
      ocupado_q   <= 1'b0;
      fim_q       <= 1'b0;
    end else begin
      fim_q <= 1'b0;
      case (state_q)
        RECEBE: begin
          if (bus.rx_pronto) begin
            if (rx_byte_q == B_LAST) begin
              rx_byte_q <= '0;
              x_q       <= '0;
              y_q       <= '0;
              mode_q    <= bus.mode;
              ocupado_q <= 1'b1;
              state_q   <= CALCULA;
            end else begin
              rx_byte_q <= rx_byte_q + BW'(1);
            end
          end
        end
        CALCULA: begin
          if (x_q == X_LAST) begin
            x_q <= '0;
            if (y_q == Y_LAST) begin
              y_q         <= '0;
              tx_byte_q   <= '0;
              tx_dados_q  <= tx_next_d;
              tx_valido_q <= 1'b1;
              state_q     <= TRANSMITE;
            end else begin
              y_q <= y_q + YW'(1);
            end
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        TRANSMITE: begin
          if (tx_valido_q && bus.tx_pronto) begin
            if (tx_byte_q == B_LAST) begin
              tx_byte_q   <= '0;
              tx_valido_q <= 1'b0;
              fim_q       <= 1'b1;
              ocupado_q   <= 1'b0;
              state_q     <= RECEBE;
            end else begin
              tx_byte_q  <= tx_byte_q + BW'(1);
              tx_dados_q <= tx_next_d;
            end
          end
        end
        default: state_q <= RECEBE;
      endcase
    end
  end

  assign bus.tx_dados   = tx_dados_q;
  assign bus.tx_valido  = tx_valido_q;
  assign bus.ocupado    = ocupado_q;
  assign bus.fim_imagem = fim_q;
endmodule

// File: tb/tb_sobel_stream_unit.sv
// Directed bench for sobel_stream_unit on a 4x4 frame of 4-bit pixels.
module tb_sobel_stream_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] frame_in  [8];
  logic [7:0] frame_exp [8];

  always #5 clock = ~clock;

  sobel_stream_if bus_if ();

  sobel_stream_unit #(.WIDTH(4), .HEIGHT(4), .PIXEL_BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [1:0] m);
    bus_if.mode = m;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      bus_if.rx_dados  = frame_in[i];
      bus_if.rx_pronto = 1'b1;
      @(posedge clock); #1;
      bus_if.rx_pronto = 1'b0;
    end
    @(negedge clock);
    check("ocupado_after_rx", bus_if.ocupado, 1);
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      bus_if.rx_dados  = 8'hA5;
      bus_if.rx_pronto = 1'b1;
      @(posedge clock); #1;
      bus_if.rx_pronto = 1'b0;
    end
  endtask

  task automatic collect(input string tag, input int stall_after);
    int n   = 0;
    int cyc = 0;
    bus_if.tx_pronto = 1'b1;
    while (n < 8 && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (bus_if.tx_valido && bus_if.tx_pronto) begin
        check($sformatf("%s_byte%0d", tag, n), bus_if.tx_dados, frame_exp[n]);
        if (n == 0) check($sformatf("%s_fim_early", tag), bus_if.fim_imagem, 0);
        n++;
        if (n == stall_after) begin
          @(posedge clock); #1;
          bus_if.tx_pronto = 1'b0;
          bus_if.rx_pronto = 1'b1;
          bus_if.rx_dados  = 8'h5A;
          for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            check($sformatf("%s_stall_valid%0d", tag, s), bus_if.tx_valido, 1);
            check($sformatf("%s_stall_data%0d", tag, s), bus_if.tx_dados, frame_exp[n]);
          end
          @(posedge clock); #1;
          bus_if.tx_pronto = 1'b1;
          bus_if.rx_pronto = 1'b0;
        end
      end
    end
    check($sformatf("%s_byte_count", tag), n, 8);
    @(negedge clock);
    check($sformatf("%s_fim_pulse", tag), bus_if.fim_imagem, 1);
    check($sformatf("%s_valid_drop", tag), bus_if.tx_valido, 0);
    check($sformatf("%s_idle", tag), bus_if.ocupado, 0);
    @(negedge clock);
    check($sformatf("%s_fim_single", tag), bus_if.fim_imagem, 0);
  endtask

  initial begin
    bus_if.mode      = 2'd0;
    bus_if.rx_dados  = 8'h00;
    bus_if.rx_pronto = 1'b0;
    bus_if.tx_pronto = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tx_valido", bus_if.tx_valido, 0);
    check("rst_ocupado", bus_if.ocupado, 0);
    check("rst_fim", bus_if.fim_imagem, 0);
    check("rst_tx_dados", bus_if.tx_dados, 8'h00);
    @(posedge clock); #1;
    reset = 1'b1;

    // Uniform frame: no gradient anywhere.
    frame_in  = '{8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77};
    frame_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2'd0);
    collect("uniform", -1);

    // Vertical step edge saturates both interior columns.
    frame_in  = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    frame_exp = '{8'h00, 8'h00, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h00, 8'h00};
    send_frame(2'd0);
    collect("vedge", -1);

    // Single pixel of value 1 at (1,1): weights 2/2/1+1 around it; mode change during CALCULA ignored.
    frame_in  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame_exp = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h02, 8'h20, 8'h00, 8'h00};
    send_frame(2'd3);
    bus_if.mode = 2'd1;
    collect("impulse", -1);

    frame_in  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    frame_exp = '{8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21, 8'h0F};
    send_frame(2'd1);
    collect("invert", -1);

    // Passthrough with stray RX strobes during CALCULA and a 5-cycle TX stall.
    frame_exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_frame(2'd2);
    junk(4);
    collect("pass_stall", 3);

    // Abort a frame mid-CALCULA, then run a fresh frame.
    frame_in = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(2'd2);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("abort_ocupado", bus_if.ocupado, 0);
    check("abort_tx_valido", bus_if.tx_valido, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    frame_in  = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    frame_exp = '{8'h00, 8'h00, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h00, 8'h00};
    send_frame(2'd0);
    collect("after_abort", -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
